// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: opcode, arbiter FSM state, default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef logic [2:0] opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY,
    ST_RESPOND
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PTRW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PTRW-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o
);

  logic [PTRW:0]   sum;
  logic [PTRW-1:0] idx;
  logic            found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_i} + (PTRW+1)'(k);
      if (sum >= (PTRW+1)'(NREQ)) sum = sum - (PTRW+1)'(NREQ);
      idx = sum[PTRW-1:0];
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU/shifter among NREQ requesters, one operation in flight at a time.
// Optional alu_done watchdog enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = ALU_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_opcode,
  input  logic [WIDTH*NREQ-1:0] req_opa,
  input  logic [WIDTH*NREQ-1:0] req_opb,
  output logic                  alu_start,
  output opcode_t               alu_opcode,
  output logic [WIDTH-1:0]      alu_opa,
  output logic [WIDTH-1:0]      alu_opb,
  input  logic                  alu_done,
  input  logic [WIDTH-1:0]      alu_result,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_err
);

  localparam int PTRW = $clog2(NREQ);

  arb_state_e       state_q, state_d;
  logic [PTRW-1:0]  ptr_q, ptr_d;
  logic [PTRW-1:0]  owner_q, owner_d;
  logic [PTRW-1:0]  gnt_idx;
  logic [NREQ-1:0]  grant;
  opcode_t          op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gnt_idx = PTRW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    req_ready = '0;
`ifdef ALU_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready = grant;
          owner_d   = gnt_idx;
          op_d      = req_opcode[3*gnt_idx +: 3];
          opa_d     = req_opa[WIDTH*gnt_idx +: WIDTH];
          opb_d     = req_opb[WIDTH*gnt_idx +: WIDTH];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // alu_done seen here belongs to nobody: the unit has at least one cycle of latency
        state_d = ST_BUSY;
`ifdef ALU_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_BUSY: begin
        if (alu_done) begin
          res_d   = alu_result;
          state_d = ST_RESPOND;
`ifdef ALU_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESPOND;
        end else begin
          cnt_d   = cnt_q + CNTW'(1);
`endif
        end
      end
      ST_RESPOND: begin
        if (rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
          ptr_d   = (owner_q == PTRW'(NREQ - 1)) ? '0 : owner_q + PTRW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == ST_RESPOND) rsp_valid[owner_q] = 1'b1;
  end

  assign alu_start  = (state_q == ST_ISSUE);
  assign alu_opcode = op_q;
  assign alu_opa    = opa_q;
  assign alu_opb    = opb_q;
  assign rsp_result = res_q;

`ifdef ALU_ARB_TIMEOUT_EN
  assign rsp_err = (state_q == ST_RESPOND) & err_q;
`else
  // No watchdog: the error flag can never be raised.
  assign rsp_err = 1'b0 & (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: transaction-level model checked every cycle plus literal expectations.
module tb_alu_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int TMO  = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [3*NREQ-1:0] req_opcode;
  logic [W*NREQ-1:0] req_opa, req_opb;
  logic              alu_start, alu_done;
  logic [2:0]        alu_opcode;
  logic [W-1:0]      alu_opa, alu_opb, alu_result;
  logic [NREQ-1:0]   rsp_valid, rsp_ready;
  logic [W-1:0]      rsp_result;
  logic              rsp_err;

  always #5 clock = ~clock;

  alu_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_opa(req_opa), .req_opb(req_opb),
    .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_opa(alu_opa), .alu_opb(alu_opb),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Behaviour of the bench's ALU; any deterministic function of the operands will do.
  function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a << b[4:0];
      3'd5: return a >> b[4:0];
      3'd6: return a ^ b;
      default: return a;
    endcase
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Observation logs (cycle numbers and values seen on the DUT ports)
  int g_idx[$], g_cyc[$], s_cyc[$], f_cyc[$], a_cyc[$], a_res[$], a_vec[$], a_err[$];
  int cyc = 0;

  // ALU responder controls
  int alu_lat  = 3;
  bit alu_auto = 1'b1;
  int stray_req = 0;

  initial begin
    int cnt, stray_seen;
    logic [2:0] op_l;
    logic [W-1:0] a_l, b_l;
    cnt = 0; stray_seen = 0; op_l = '0; a_l = '0; b_l = '0;
    alu_done = 1'b0;
    alu_result = '0;
    forever begin
      @(posedge clock); #2;
      alu_done = 1'b0;
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        alu_done   = 1'b1;
        alu_result = 32'hDEAD_BEEF;
      end else if (cnt == 1) begin
        alu_done   = 1'b1;
        alu_result = alu_f(op_l, a_l, b_l);
      end
      if (cnt > 0) cnt--;
      if (alu_start && alu_auto) begin
        cnt = alu_lat; op_l = alu_opcode; a_l = alu_opa; b_l = alu_opb;
      end
    end
  end

  // Model: one transaction at a time; grant -> launch next cycle -> first done after launch -> respond until owner accepts.
  initial begin
    int m_ptr, m_owner, m_wcnt, pick;
    bit m_start_due, m_wait, m_have, m_err;
    logic [2:0] m_op;
    logic [W-1:0] m_a, m_b, m_res;
    logic [NREQ-1:0] exp_rdy, exp_v, prev_v;
    m_ptr = 0; m_owner = -1; m_wcnt = 0; pick = -1;
    m_start_due = 0; m_wait = 0; m_have = 0; m_err = 0;
    m_op = '0; m_a = '0; m_b = '0; m_res = '0; exp_rdy = '0; exp_v = '0; prev_v = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        chk("reset_ctrl", {req_ready, alu_start, rsp_valid, rsp_err, alu_opcode}, '0);
        chk("reset_data", {alu_opa, alu_opb}, '0);
        chk("reset_result", rsp_result, '0);
        m_ptr = 0; m_owner = -1; m_start_due = 0; m_wait = 0; m_have = 0; m_err = 0;
        prev_v = '0;
      end else begin
        pick    = (m_owner < 0) ? rr_pick(req_valid, m_ptr) : -1;
        exp_rdy = (pick >= 0) ? (NREQ'(1) << pick) : '0;
        exp_v   = m_have ? (NREQ'(1) << m_owner) : '0;
        chk("req_ready", req_ready, exp_rdy);
        chk("alu_start", alu_start, m_start_due);
        chk("rsp_valid", rsp_valid, exp_v);
        chk("rsp_err", rsp_err, m_have & m_err);
        if (m_have) chk("rsp_result", rsp_result, m_res);
        if (m_owner >= 0 && !m_have) chk("alu_operands", {alu_opcode, alu_opa, alu_opb}, {m_op, m_a, m_b});

        if (req_ready != 0) begin g_idx.push_back(rr_pick(req_ready, 0)); g_cyc.push_back(cyc); end
        if (alu_start) s_cyc.push_back(cyc);
        if (rsp_valid != 0 && prev_v == 0) f_cyc.push_back(cyc);
        if ((rsp_valid & rsp_ready) != 0) begin
          a_cyc.push_back(cyc); a_res.push_back(int'(rsp_result));
          a_vec.push_back(int'(rsp_valid)); a_err.push_back(int'(rsp_err));
        end
        prev_v = rsp_valid;

        if (m_have && rsp_ready[m_owner]) begin
          m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_have = 0; m_err = 0;
        end else if (m_wait) begin
          m_wcnt++;
          if (alu_done) begin
            m_have = 1; m_res = alu_f(m_op, m_a, m_b); m_wait = 0;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          else if (m_wcnt == TMO) begin
            m_have = 1; m_res = '0; m_err = 1; m_wait = 0;
          end
`endif
        end
        if (m_start_due) begin m_start_due = 0; m_wait = 1; m_wcnt = 0; end
        if (pick >= 0) begin
          m_owner = pick; m_start_due = 1;
          m_op = req_opcode[3*pick +: 3]; m_a = req_opa[W*pick +: W]; m_b = req_opb[W*pick +: W];
        end
      end
    end
  end

  bit oneshot = 1'b0;

  task automatic step();
    logic [NREQ-1:0] rdy_s;
    @(negedge clock);
    rdy_s = req_ready;
    @(posedge clock); #1;
    if (oneshot) req_valid = req_valid & ~rdy_s;
  endtask

  function automatic int log_size(input int which);
    case (which)
      0: return g_idx.size();
      1: return f_cyc.size();
      default: return a_cyc.size();
    endcase
  endfunction

  task automatic wait_log(input int which, input int target, input int budget, input string nm);
    int b = budget;
    while (log_size(which) < target && b > 0) begin step(); b--; end
    if (log_size(which) < target) chk(nm, 72'(log_size(which)), 72'(target));
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_opcode[3*i +: 3] = op;
    req_opa[W*i +: W]    = a;
    req_opb[W*i +: W]    = b;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int bg, bs, bf, ba;
    int rr_exp[5];
    rr_exp = '{0, 1, 2, 3, 0};
    req_valid = '0; req_opcode = '0; req_opa = '0; req_opb = '0; rsp_ready = '1;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    chk("init_reset_outputs", {req_ready, alu_start, rsp_valid, rsp_err, rsp_result}, '0);
    @(posedge clock); #1;
    reset = 1'b1;
    step();

    // All four requesting continuously, responses accepted at once
    for (int i = 0; i < NREQ; i++) set_req(i, 3'd0, W'(32'h100 * (i + 1)), W'(i));
    alu_lat = 1; oneshot = 0;
    bg = g_idx.size(); ba = a_cyc.size();
    req_valid = '1;
    wait_log(0, bg + 5, 80, "rr_grants_timeout");
    req_valid = '0;
    wait_log(2, ba + 5, 40, "rr_accepts_timeout");
    for (int k = 0; k < 5; k++) chk($sformatf("rr_order_%0d", k), 72'(qget(g_idx, bg + k)), 72'(rr_exp[k]));
    chk("rr_result_0", 72'(32'(qget(a_res, ba))), 72'(32'h100));
    chk("rr_result_3", 72'(32'(qget(a_res, ba + 3))), 72'(32'h403));

    // Single request from requester 2: shift 1 left by 5, ALU latency 3
    alu_lat = 3; oneshot = 1;
    set_req(2, 3'b100, 32'h0000_0001, 32'd5);
    bg = g_idx.size(); bs = s_cyc.size(); bf = f_cyc.size(); ba = a_cyc.size();
    req_valid = 4'b0100;
    wait_log(2, ba + 1, 30, "single_timeout");
    chk("single_grant_idx", 72'(qget(g_idx, bg)), 72'd2);
    chk("single_grant_count", 72'(g_idx.size() - bg), 72'd1);
    chk("single_start_lat", 72'(qget(s_cyc, bs) - qget(g_cyc, bg)), 72'd1);
    chk("single_rsp_lat", 72'(qget(f_cyc, bf) - qget(g_cyc, bg)), 72'd5);
    chk("single_result", 72'(32'(qget(a_res, ba))), 72'(32'h20));
    chk("single_rsp_vec", 72'(qget(a_vec, ba)), 72'(4'b0100));

    // Owner holds rsp_ready low for 5 RESPOND cycles while another requester waits
    alu_lat = 2;
    set_req(1, 3'd0, 32'd7, 32'd9);
    set_req(3, 3'd2, 32'hFF00, 32'h0FF0);
    bg = g_idx.size(); bf = f_cyc.size(); ba = a_cyc.size();
    rsp_ready = 4'b1101;
    req_valid = 4'b0010;
    wait_log(1, bf + 1, 20, "hold_rsp_timeout");
    req_valid[3] = 1'b1;
    repeat (4) step();
    chk("hold_no_new_grant", 72'(g_idx.size() - bg), 72'd1);
    chk("hold_no_accept", 72'(a_cyc.size() - ba), 72'd0);
    rsp_ready = '1;
    wait_log(2, ba + 2, 30, "hold_accept_timeout");
    chk("hold_accept_lat", 72'(qget(a_cyc, ba) - qget(f_cyc, bf)), 72'd5);
    chk("hold_result", 72'(32'(qget(a_res, ba))), 72'd16);
    chk("hold_next_grant", 72'(qget(g_idx, bg + 1)), 72'd3);
    chk("hold_next_result", 72'(32'(qget(a_res, ba + 1))), 72'(32'h0F00));

    // Stray alu_done in IDLE, then in ISSUE
    bf = f_cyc.size();
    stray_req++;
    repeat (3) step();
    chk("stray_idle_no_rsp", 72'(f_cyc.size() - bf), 72'd0);
    alu_lat = 4;
    set_req(0, 3'd1, 32'd100, 32'd1);
    bg = g_idx.size(); ba = a_cyc.size();
    req_valid = 4'b0001;
    wait_log(0, bg + 1, 20, "stray_grant_timeout");
    stray_req++;
    wait_log(2, ba + 1, 30, "stray_issue_timeout");
    chk("stray_issue_rsp_lat", 72'(qget(f_cyc, bf) - qget(g_cyc, bg)), 72'd6);
    chk("stray_issue_result", 72'(32'(qget(a_res, ba))), 72'd99);

    // Reset while BUSY; the late alu_done must be ignored
    alu_lat = 6;
    set_req(2, 3'd6, 32'd5, 32'd3);
    bg = g_idx.size(); bf = f_cyc.size(); ba = a_cyc.size();
    req_valid = 4'b0100;
    wait_log(0, bg + 1, 20, "rst_grant_timeout");
    step(); step();
    reset = 1'b0;
    @(negedge clock);
    chk("busy_rst_ctrl", {req_ready, alu_start, rsp_valid, rsp_err, alu_opcode}, '0);
    chk("busy_rst_data", {alu_opa, alu_opb, rsp_result}, '0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (6) step();
    chk("busy_rst_no_rsp", 72'(f_cyc.size() - bf), 72'd0);
    alu_lat = 2;
    set_req(1, 3'd5, 32'h80, 32'd3);
    bg = g_idx.size(); ba = a_cyc.size();
    req_valid = 4'b0010;
    wait_log(2, ba + 1, 30, "after_rst_timeout");
    chk("after_rst_grant", 72'(qget(g_idx, bg)), 72'd1);
    chk("after_rst_result", 72'(32'(qget(a_res, ba))), 72'(32'h10));

`ifdef ALU_ARB_TIMEOUT_EN
    // Watchdog: the ALU never answers
    alu_auto = 1'b0;
    set_req(3, 3'd0, 32'd1, 32'd1);
    bg = g_idx.size(); bf = f_cyc.size(); ba = a_cyc.size();
    req_valid = 4'b1000;
    wait_log(2, ba + 1, 40, "tmo_timeout");
    chk("tmo_rsp_lat", 72'(qget(f_cyc, bf) - qget(g_cyc, bg)), 72'(2 + TMO));
    chk("tmo_result", 72'(32'(qget(a_res, ba))), 72'd0);
    chk("tmo_err", 72'(qget(a_err, ba)), 72'd1);
    alu_auto = 1'b1;
`endif

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-003 SHALL have parameter TIMEOUT, default 64, alu_done watchdog limit in cycles (used only under ALU_ARB_TIMEOUT_EN).
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-007 SHALL have port req_ready  output  NREQ  per-requester accept, one-hot or zero.
REQ-008 SHALL have port req_opcode  input  3*NREQ  packed opcodes, requester i at [3i+2:3i].
REQ-009 SHALL have port req_opa, req_opb  input  WIDTH*NREQ  packed operands.
REQ-010 SHALL have port alu_start  output  1  one-cycle launch pulse to shared ALU/shifter.
REQ-011 SHALL have port alu_opcode, alu_opa, alu_opb  output  3/WIDTH/WIDTH  registered operands to shared unit.
REQ-012 SHALL have port alu_done, alu_result  input  1/WIDTH  completion pulse and result from shared unit.
REQ-013 SHALL have port rsp_valid  output  NREQ  one-hot result-valid to owning requester.
REQ-014 SHALL have port rsp_ready  input  NREQ  requester accepts result.
REQ-015 SHALL have port rsp_result  output  WIDTH  result shared by all requesters.
REQ-016 SHALL have port rsp_err  output  1  timeout flag qualified by rsp_valid (constant 0 without ALU_ARB_TIMEOUT_EN).

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> BUSY -> RESPOND -> IDLE.
REQ-018 IDLE: if any req_valid, SHALL grant one requester by round-robin starting at index ptr, assert req_ready[grant] for exactly that cycle, latch its opcode/operands and owner index, go to ISSUE.
REQ-019 ISSUE: SHALL assert alu_start for exactly one cycle with latched operands, go to BUSY.
REQ-020 BUSY: SHALL hold alu_opcode/opa/opb stable; on alu_done SHALL latch alu_result, go to RESPOND.
REQ-021 RESPOND: SHALL assert rsp_valid[owner] with rsp_result until rsp_ready[owner] is high; on that cycle go to IDLE and set ptr to owner+1 modulo NREQ.
REQ-022 Requester latency from grant to earliest rsp_valid SHALL be 2 cycles plus ALU latency.
REQ-023 SHALL ignore alu_done outside BUSY; SHALL ignore rsp_ready of non-owners.
REQ-024 Simultaneous requests SHALL be served in round-robin order; no requester waits more than NREQ-1 grants.
REQ-025 ptr wrap from NREQ-1 SHALL go to 0.
REQ-026 Requester deasserting req_valid before grant SHALL not be granted; no request is queued.
REQ-027 alu_done in the same cycle as alu_start SHALL be ignored (unit latency >= 1).

Reset
REQ-028 On reset low SHALL immediately force state IDLE, ptr 0, req_ready 0, alu_start 0, rsp_valid 0, rsp_err 0, rsp_result 0, alu_opcode/opa/opb 0.
REQ-029 Reset mid-operation SHALL discard the in-flight operation without response; a subsequent alu_done SHALL be ignored.

Configuration
REQ-030 With ALU_ARB_TIMEOUT_EN defined, SHALL count BUSY cycles; at TIMEOUT without alu_done SHALL go to RESPOND with rsp_result 0 and rsp_err 1.
REQ-031 Without ALU_ARB_TIMEOUT_EN, BUSY SHALL wait indefinitely and rsp_err SHALL be tied 0.

Structure
REQ-032 Package alu_pkg SHALL hold the opcode typedef (3-bit), arbiter state enum, and default WIDTH constant.
REQ-033 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs request vector, ptr; output one-hot grant, combinational).

Verification
REQ-034 Single request: req_valid[2], opcode 3'b100, opa 0x0000_0001, opb 5, ALU returns 0x20 after 3 cycles -> req_ready[2] one cycle, alu_start one cycle later, rsp_valid[2] with 0x20, no other rsp_valid.
REQ-035 All four requesting continuously, rsp_ready tied 1 -> grant order 0,1,2,3,0; ptr wraps.
REQ-036 rsp_ready[1] held low 5 cycles in RESPOND -> rsp_valid[1] and rsp_result stable, no new grant until acceptance.
REQ-037 Reset asserted in BUSY, alu_done pulsed after reset release -> all outputs 0, no rsp_valid, next request served normally.
REQ-038 ALU_ARB_TIMEOUT_EN, TIMEOUT 8, alu_done never pulsed -> rsp_valid after 8 BUSY cycles, rsp_result 0, rsp_err 1.
REQ-039 Stray alu_done in IDLE and in ISSUE -> no state change, no rsp_valid.
